spi_subunit_core: RTL and testbench

Synthesizable, parametrised SPI subunit (peripheral) core clocked from the system clock. It oversamples the external `sclk`, `cs` and `mosi` pins through synchronizers and supports all four SPI modes and a configurable word width. It streams back-to-back words while `cs` is held low, with a valid/ready transmit holding register and a one-cycle receive strobe. It sits between the board SPI pins and the user logic.

---
 rtl/spi_subunit_core.sv | 150 +++++++++++++++
 tb/tb_spi_subunit_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_subunit_core.sv
// SPI peripheral core: oversampled pins, all four SPI modes, back-to-back words.
// Optional frame error reporting is enabled with `define SPI_SUBUNIT_FRAME_ERR_EN.
module spi_subunit_core #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    CPOL       = 1'b0,
    parameter bit                    CPHA       = 1'b0,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            sclk_sync_reg;
    logic [2:0]            cs_sync_reg;
    logic [1:0]            mosi_sync_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [DATA_WIDTH-2:0] rx_shift_reg;
    logic [DATA_WIDTH-1:0] tx_shift_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  hold_full_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic                  rx_valid_reg;
    logic                  tx_underrun_reg;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, active, abort, do_sample, do_shift;
    logic word_load, word_done, accept;
    logic [DATA_WIDTH-1:0] rx_word;

    // cs chain resets low so a select already asserted at reset release is not seen as a fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= {3{CPOL}};
            cs_sync_reg   <= 3'b000;
            mosi_sync_reg <= 2'b00;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
            cs_sync_reg   <= {cs_sync_reg[1:0], cs};
            mosi_sync_reg <= {mosi_sync_reg[0], mosi};
        end
    end

    assign sclk_rise   = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall   = ~sclk_sync_reg[1] & sclk_sync_reg[2];
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_sync_reg[1] & cs_sync_reg[2];
    assign cs_rise     = cs_sync_reg[1] & ~cs_sync_reg[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // A cs rise in the same cycle as an sclk edge suppresses that edge
    assign active    = (state_reg == ST_ACTIVE);
    assign abort     = active & cs_rise;
    assign do_sample = active & ~cs_rise & sample_edge;
    assign do_shift  = active & ~cs_rise & shift_edge;
    // With bit_cnt at zero the shift edge is either the first of a word (CPHA=1)
    // or the one right after the last sample (CPHA=0): both start a new word
    assign word_load = (~active & cs_fall & ~CPHA) | (do_shift & (bit_cnt_reg == '0));
    assign word_done = do_sample & (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1));
    assign accept    = tx_valid & ~hold_full_reg;
    assign rx_word   = {rx_shift_reg, mosi_sync_reg[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg     <= '0;
            rx_shift_reg    <= '0;
            tx_shift_reg    <= '0;
            hold_reg        <= '0;
            hold_full_reg   <= 1'b0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            tx_underrun_reg <= 1'b0;
        end else begin
            if (abort) begin
                bit_cnt_reg  <= '0;
                rx_shift_reg <= '0;
            end else if (do_sample) begin
                rx_shift_reg <= rx_word[DATA_WIDTH-2:0];
                bit_cnt_reg  <= word_done ? '0 : bit_cnt_reg + 1'b1;
            end

            if (word_load)
                tx_shift_reg <= hold_full_reg ? hold_reg : DEFAULT_TX;
            else if (do_shift)
                tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};

            // The load uses the old content; a same-cycle accept refills the register
            if (accept)
                hold_reg <= tx_data;
            hold_full_reg <= accept | (hold_full_reg & ~word_load);

            if (word_done)
                rx_data_reg <= rx_word;
            rx_valid_reg    <= word_done;
            tx_underrun_reg <= word_load & ~hold_full_reg;
        end
    end

`ifdef SPI_SUBUNIT_FRAME_ERR_EN
    logic frame_err_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err_reg <= 1'b0;
        else        frame_err_reg <= abort & (bit_cnt_reg != '0);
    end
    assign frame_err = frame_err_reg;
`else
    assign frame_err = 1'b0;
`endif

    assign miso        = tx_shift_reg[DATA_WIDTH-1];
    assign miso_oe     = active & ~cs_sync_reg[1];
    assign busy        = active & ~cs_sync_reg[1];
    assign tx_ready    = ~hold_full_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign tx_underrun = tx_underrun_reg;

endmodule

// File: tb/tb_spi_subunit_core.sv
// Directed bench for spi_subunit_core: an 8-bit mode-0 core plus four 16-bit cores, one per mode.
module tb_spi_subunit_core;
    localparam int H = 8;
`ifdef SPI_SUBUNIT_FRAME_ERR_EN
    localparam int FE_EXP = 1;
`else
    localparam int FE_EXP = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sclk, cs, mosi, tx_valid;
    logic [7:0] tx_data;
    wire        miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err, busy;
    wire  [7:0] rx_data;

    logic [3:0]  sclk16, cs16, mosi16, tv16;
    logic [15:0] td16;
    wire  [3:0]  miso16, oe16, rdy16, rv16, un16, fe16, busy16;
    wire  [15:0] rd16 [4];

    int n_checks = 0;
    int n_pass   = 0;
    int rx_cnt = 0, un_cnt = 0, fe_cnt = 0;
    int rx16_cnt [4] = '{0, 0, 0, 0};

    spi_subunit_core #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam bit LCPOL = (gi >= 2);
        localparam bit LCPHA = ((gi % 2) == 1);
        spi_subunit_core #(.DATA_WIDTH(16), .CPOL(LCPOL), .CPHA(LCPHA), .DEFAULT_TX(16'h0000)) u_lane (
            .clk(clk), .rst_n(rst_n), .sclk(sclk16[gi]), .cs(cs16[gi]), .mosi(mosi16[gi]),
            .miso(miso16[gi]), .miso_oe(oe16[gi]), .tx_data(td16), .tx_valid(tv16[gi]),
            .tx_ready(rdy16[gi]), .rx_data(rd16[gi]), .rx_valid(rv16[gi]),
            .tx_underrun(un16[gi]), .frame_err(fe16[gi]), .busy(busy16[gi])
        );
    end

    always @(posedge clk) begin
        if (rx_valid)    rx_cnt <= rx_cnt + 1;
        if (tx_underrun) un_cnt <= un_cnt + 1;
        if (frame_err)   fe_cnt <= fe_cnt + 1;
        for (int k = 0; k < 4; k++)
            if (rv16[k]) rx16_cnt[k] <= rx16_cnt[k] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_ready && t < 50) begin
            wait_clk(1);
            t++;
        end
        check("load_ready_wait", 32'(t < 50), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("load_tx_ready_low", 32'(tx_ready), 32'd0);
    endtask

    // Mode-0 master bits; ending a frame raises cs before the last falling edge
    task automatic bits8(input logic [7:0] mo, input int nbits, input bit end_frame,
                         output logic [7:0] mi);
        mi = '0;
        for (int k = 0; k < nbits; k++) begin
            mosi = mo[7-k];
            wait_clk(H);
            mi[7-k] = miso;
            sclk = 1'b1;
            wait_clk(H);
            if (end_frame && k == nbits - 1) begin
                cs = 1'b1;
                wait_clk(H);
            end
            sclk = 1'b0;
        end
        if (end_frame) wait_clk(H);
    endtask

    task automatic xfer16(input int m, input logic [15:0] mo, output logic [15:0] mi);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = ((m % 2) == 1);
        mi = '0;
        cs16[m] = 1'b0;
        wait_clk(H);
        for (int k = 0; k < 16; k++) begin
            if (!cpha) begin
                mosi16[m] = mo[15-k];
                wait_clk(H);
                mi[15-k] = miso16[m];
                sclk16[m] = ~cpol;
                wait_clk(H);
                if (k == 15) begin
                    cs16[m] = 1'b1;
                    wait_clk(H);
                end
                sclk16[m] = cpol;
            end else begin
                wait_clk(H);
                sclk16[m] = ~cpol;
                mosi16[m] = mo[15-k];
                wait_clk(H);
                mi[15-k] = miso16[m];
                sclk16[m] = cpol;
            end
        end
        wait_clk(H);
        cs16[m] = 1'b1;
        wait_clk(H);
    endtask

    initial begin
        logic [7:0]  mi, mi2, mi3;
        logic [15:0] mi16;
        int rx0, un0, fe0, r16;

        rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        sclk16 = 4'b1100; cs16 = 4'hF; mosi16 = '0; tv16 = '0; td16 = 16'h1234;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(tx_underrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Single word, mode 0
        load8(8'hA5);
        rx0 = rx_cnt; un0 = un_cnt;
        cs = 1'b0;
        wait_clk(H);
        check("w1_busy", 32'(busy), 32'd1);
        check("w1_miso_oe", 32'(miso_oe), 32'd1);
        check("w1_tx_ready_after_load", 32'(tx_ready), 32'd1);
        bits8(8'h3C, 8, 1'b1, mi);
        check("w1_miso_word", 32'(mi), 32'hA5);
        check("w1_rx_data", 32'(rx_data), 32'h3C);
        check("w1_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("w1_underruns", 32'(un_cnt - un0), 32'd0);
        check("w1_busy_after", 32'(busy), 32'd0);

        // Back-to-back: three words, two loaded
        load8(8'h11);
        rx0 = rx_cnt; un0 = un_cnt;
        cs = 1'b0;
        wait_clk(H);
        load8(8'h22);
        bits8(8'hC1, 8, 1'b0, mi);
        check("b2b_rx1", 32'(rx_data), 32'hC1);
        bits8(8'h5E, 8, 1'b0, mi2);
        check("b2b_rx2", 32'(rx_data), 32'h5E);
        check("b2b_underrun_before_w3", 32'(un_cnt - un0), 32'd0);
        bits8(8'h7B, 8, 1'b1, mi3);
        check("b2b_miso1", 32'(mi), 32'h11);
        check("b2b_miso2", 32'(mi2), 32'h22);
        check("b2b_miso3", 32'(mi3), 32'hFF);
        check("b2b_rx3", 32'(rx_data), 32'h7B);
        check("b2b_rx_pulses", 32'(rx_cnt - rx0), 32'd3);
        check("b2b_underruns", 32'(un_cnt - un0), 32'd1);

        // Abort after 5 bits, then a clean word
        rx0 = rx_cnt; fe0 = fe_cnt;
        cs = 1'b0;
        wait_clk(H);
        bits8(8'hE7, 5, 1'b1, mi);
        check("abort_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
        check("abort_frame_err", 32'(fe_cnt - fe0), 32'(FE_EXP));
        check("abort_rx_data_held", 32'(rx_data), 32'h7B);
        cs = 1'b0;
        wait_clk(H);
        bits8(8'h96, 8, 1'b1, mi);
        check("after_abort_rx", 32'(rx_data), 32'h96);
        check("after_abort_pulses", 32'(rx_cnt - rx0), 32'd1);

        // Reset mid-word after 3 bits
        load8(8'h77);
        cs = 1'b0;
        wait_clk(H);
        load8(8'hC3);
        bits8(8'hE0, 3, 1'b0, mi);
        wait_clk(6);
        check("pre_rst_miso", 32'(miso), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(miso), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_rx_data", 32'(rx_data), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_miso_oe", 32'(miso_oe), 32'd0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        rx0 = rx_cnt;
        bits8(8'hFF, 8, 1'b0, mi);
        wait_clk(H);
        check("post_rst_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_miso_oe", 32'(miso_oe), 32'd0);
        cs = 1'b1;
        wait_clk(H);

        // Accept in the same cycle as the cs-fall load (register empty)
        un0 = un_cnt;
        cs = 1'b0;
        wait_clk(2);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("same_cycle_tx_ready", 32'(tx_ready), 32'd0);
        check("same_cycle_underrun", 32'(tx_underrun), 32'd1);
        wait_clk(H - 3);
        bits8(8'h00, 8, 1'b1, mi);
        check("same_cycle_old_word", 32'(mi), 32'hFF);
        check("same_cycle_ready_after", 32'(tx_ready), 32'd0);
        cs = 1'b0;
        wait_clk(H);
        bits8(8'h00, 8, 1'b1, mi);
        check("same_cycle_new_word", 32'(mi), 32'h5A);
        check("same_cycle_underruns", 32'(un_cnt - un0), 32'd1);

        // Four modes at 16 bits
        for (int m = 0; m < 4; m++) begin
            tv16[m] = 1'b1;
            wait_clk(1);
            tv16[m] = 1'b0;
            check($sformatf("m%0d_tx_ready_low", m), 32'(rdy16[m]), 32'd0);
            r16 = rx16_cnt[m];
            xfer16(m, 16'hBEEF, mi16);
            check($sformatf("m%0d_miso_word", m), 32'(mi16), 32'h1234);
            check($sformatf("m%0d_rx_data", m), 32'(rd16[m]), 32'hBEEF);
            check($sformatf("m%0d_rx_pulses", m), 32'(rx16_cnt[m] - r16), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
